// File: rtl/umix_pkg.sv
// ----------------------------------------------------------------------------
// umix_pkg
// Shared types for the UM program loader front end.
//   platter_t         : one 32-bit UM platter
//   byte_t            : one scroll byte
//   BYTES_PER_PLATTER : bytes packed into one platter (big-endian)
//   loader_state_t    : FILL (normal byte packing), PEND (flushed partial
//                       word waiting for the output slot to free up)
// ----------------------------------------------------------------------------
package umix_pkg;

  typedef logic [31:0] platter_t;
  typedef logic [7:0]  byte_t;

  localparam int BYTES_PER_PLATTER = 4;

  typedef enum logic {
    FILL = 1'b0,
    PEND = 1'b1
  } loader_state_t;

endpackage

// File: rtl/um_word_index.sv
// ----------------------------------------------------------------------------
// um_word_index
// Word index counter for the loader. Advances by one on each enabled cycle,
// wrapping modulo 2^addr_bits, and raises a sticky flag the first time it
// wraps from 2^addr_bits-1 back to 0. Only reset clears the flag.
//
// Ports:
//   clk      rising-edge clock
//   r_n      asynchronous active-low reset
//   inc      advance the index this cycle
//   index    current word index
//   wrapped  sticky wrap indicator
// ----------------------------------------------------------------------------
module um_word_index #(
  parameter int addr_bits = 16
) (
  input  logic                 clk,
  input  logic                 r_n,
  input  logic                 inc,
  output logic [addr_bits-1:0] index,
  output logic                 wrapped
);

  logic [addr_bits-1:0] index_reg;
  logic                 wrapped_reg;

  always_ff @(posedge clk or negedge r_n) begin
    if (!r_n) begin
      index_reg   <= '0;
      wrapped_reg <= 1'b0;
    end else if (inc) begin
      index_reg <= index_reg + addr_bits'(1);
      if (&index_reg) begin
        wrapped_reg <= 1'b1;
      end
    end
  end

  assign index   = index_reg;
  assign wrapped = wrapped_reg;

endmodule

// File: rtl/um_word_loader.sv
// ----------------------------------------------------------------------------
// um_word_loader
// Byte-to-word front end for the UM program loader. Packs a big-endian byte
// stream into 32-bit platters (first byte -> [31:24]) and presents each one
// with its word index over a valid/ready handshake.
//
// Build option:
//   UM_WORD_LOADER_PAD_EN  defined   : flush of a partial word emits it with
//                                      zero low bytes (waiting in PEND if the
//                                      output slot is busy).
//                          undefined : flush discards partial bytes.
//
// Ports:
//   clk        rising-edge clock
//   r_n        asynchronous active-low reset
//   in_data    scroll byte
//   in_valid   in_data valid
//   in_ready   byte accepted on in_valid && in_ready (combinational in out_ready)
//   flush      single-cycle end-of-scroll pulse
//   out_data   assembled platter
//   out_addr   word index of out_data
//   out_valid  out_data/out_addr valid
//   out_ready  word consumed on out_valid && out_ready
//   wrapped    sticky: index has wrapped
// ----------------------------------------------------------------------------
module um_word_loader
  import umix_pkg::*;
#(
  parameter int addr_bits = 16
) (
  input  logic                 clk,
  input  logic                 r_n,
  input  logic [7:0]           in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 flush,
  output logic [31:0]          out_data,
  output logic [addr_bits-1:0] out_addr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 wrapped
);

  localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_PLATTER - 1);

  logic [1:0] cnt_reg, cnt_next;
  platter_t   asm_reg, asm_next;     // unfilled byte lanes are always zero
  platter_t   data_reg;
  logic       valid_reg;

  logic       accept;
  logic       handshake;
  logic       slot_free;
  logic       flush_pend;
  logic       load_word;
  platter_t   load_data;

`ifdef UM_WORD_LOADER_PAD_EN
  loader_state_t state_reg, state_next;
  assign flush_pend = (state_reg == PEND);
`else
  assign flush_pend = 1'b0;
`endif

  assign handshake = valid_reg && out_ready;
  // Output slot can take a new word this edge: empty, or being drained now.
  assign slot_free = !valid_reg || out_ready;
  assign in_ready  = !flush_pend && ((cnt_reg != LAST_BYTE) || slot_free);
  assign accept    = in_valid && in_ready;

  always_comb begin
    cnt_next  = cnt_reg;
    asm_next  = asm_reg;
    load_word = 1'b0;
    load_data = asm_reg;
`ifdef UM_WORD_LOADER_PAD_EN
    state_next = state_reg;

    // A padded word parked by an earlier flush goes out as soon as the slot
    // frees. in_ready is low in PEND, so no byte can collide with this.
    if (state_reg == PEND && slot_free) begin
      load_word  = 1'b1;
      load_data  = asm_reg;
      asm_next   = '0;
      state_next = FILL;
    end
`endif

    // Byte first; a same-cycle flush then sees the updated count.
    if (accept) begin
      if (cnt_reg == LAST_BYTE) begin
        load_word = 1'b1;
        load_data = {asm_reg[31:8], in_data};
        asm_next  = '0;
        cnt_next  = '0;
      end else begin
        case (cnt_reg)
          2'd0:    asm_next[31:24] = in_data;
          2'd1:    asm_next[23:16] = in_data;
          default: asm_next[15:8]  = in_data;
        endcase
        cnt_next = cnt_reg + 2'd1;
      end
    end

    if (flush && (cnt_next != '0)) begin
`ifdef UM_WORD_LOADER_PAD_EN
      if (slot_free) begin
        load_word = 1'b1;
        load_data = asm_next;
        asm_next  = '0;
      end else begin
        // Keep the padded word in the assembly register until the slot frees.
        state_next = PEND;
      end
`else
      asm_next = '0;
`endif
      cnt_next = '0;
    end
  end

  always_ff @(posedge clk or negedge r_n) begin
    if (!r_n) begin
      cnt_reg   <= '0;
      asm_reg   <= '0;
      data_reg  <= '0;
      valid_reg <= 1'b0;
    end else begin
      cnt_reg <= cnt_next;
      asm_reg <= asm_next;
      if (load_word) begin
        data_reg  <= load_data;
        valid_reg <= 1'b1;
      end else if (handshake) begin
        valid_reg <= 1'b0;
      end
    end
  end

`ifdef UM_WORD_LOADER_PAD_EN
  always_ff @(posedge clk or negedge r_n) begin
    if (!r_n) begin
      state_reg <= FILL;
    end else begin
      state_reg <= state_next;
    end
  end
`endif

  // The index counter only moves on a handshake, so while a word is held it
  // is exactly that word's index and can drive out_addr directly.
  um_word_index #(
    .addr_bits(addr_bits)
  ) u_word_index (
    .clk     (clk),
    .r_n     (r_n),
    .inc     (handshake),
    .index   (out_addr),
    .wrapped (wrapped)
  );

  assign out_data  = data_reg;
  assign out_valid = valid_reg;

endmodule

// File: tb/tb_um_word_loader.sv
// ----------------------------------------------------------------------------
// tb_um_word_loader
// Two loaders share one stimulus stream: the default 16-bit index build and a
// 2-bit index build for the wrap behaviour. Directed scenarios use fixed
// expectations; the random scenario uses a queue-based reference model.
// ----------------------------------------------------------------------------
module tb_um_word_loader;
  import umix_pkg::*;

`ifdef UM_WORD_LOADER_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        r_n = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;

  logic        in_ready, out_valid, wrapped;
  logic [31:0] out_data;
  logic [15:0] out_addr;
  logic        in_ready2, out_valid2, wrapped2;
  logic [31:0] out_data2;
  logic [1:0]  out_addr2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  um_word_loader #(.addr_bits(16)) dut (
    .clk(clk), .r_n(r_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .flush(flush), .out_data(out_data),
    .out_addr(out_addr), .out_valid(out_valid), .out_ready(out_ready),
    .wrapped(wrapped)
  );

  um_word_loader #(.addr_bits(2)) dut2 (
    .clk(clk), .r_n(r_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready2), .flush(flush), .out_data(out_data2),
    .out_addr(out_addr2), .out_valid(out_valid2), .out_ready(out_ready),
    .wrapped(wrapped2)
  );

  // ---------------- reference model (random scenario) ----------------
  byte_t    m_part[$];      // bytes of the word being assembled
  bit       m_ov;           // output slot occupied
  platter_t m_word;
  bit       m_pend;         // padded word waiting for the slot
  platter_t m_pend_word;
  int       m_hs;           // handshakes since reset = index of held word

  function automatic platter_t pack(input byte_t q[$]);
    platter_t w = '0;
    for (int i = 0; i < q.size(); i++) w = w | (platter_t'(q[i]) << (24 - 8 * i));
    return w;
  endfunction

  function automatic bit model_in_ready();
    return !m_pend && (m_part.size() != 3 || !m_ov || out_ready);
  endfunction

  task automatic model_advance();
    bit acc, hs, free, nov;
    platter_t nw;
    acc  = in_valid && model_in_ready();
    hs   = m_ov && out_ready;
    free = !m_ov || out_ready;
    nov  = m_ov && !hs;
    nw   = m_word;
    if (m_pend && free) begin
      nw = m_pend_word; nov = 1'b1; m_pend = 1'b0;
    end
    if (acc) begin
      m_part.push_back(in_data);
      if (m_part.size() == BYTES_PER_PLATTER) begin
        nw = pack(m_part); nov = 1'b1; m_part.delete();
      end
    end
    if (flush && m_part.size() != 0) begin
      if (PAD) begin
        if (free) begin nw = pack(m_part); nov = 1'b1; end
        else begin m_pend = 1'b1; m_pend_word = pack(m_part); end
      end
      m_part.delete();
    end
    if (hs) m_hs++;
    m_ov = nov;
    m_word = nw;
  endtask

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic drive(input bit iv, input logic [7:0] d, input bit fl, input bit ordy);
    in_valid = iv; in_data = d; flush = fl; out_ready = ordy;
    @(negedge clk);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; in_data = 8'h00;
    r_n = 1'b0;
    @(negedge clk);
    r_n = 1'b1;
    tick();
    m_part.delete(); m_ov = 1'b0; m_word = '0; m_pend = 1'b0; m_hs = 0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_data !== 32'h0) begin n_err++; $display("FAIL reset_out_data: got %h want 00000000", out_data); end
    n_cmp++; if (out_addr !== 16'h0) begin n_err++; $display("FAIL reset_out_addr: got %h want 0000", out_addr); end
    n_cmp++; if (wrapped !== 1'b0) begin n_err++; $display("FAIL reset_wrapped: got %b want 0", wrapped); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (wrapped2 !== 1'b0) begin n_err++; $display("FAIL reset_wrapped2: got %b want 0", wrapped2); end
    tick();
  endtask

  task automatic test_single_word();
    logic [7:0] b [4];
    b[0] = 8'h12; b[1] = 8'h34; b[2] = 8'h56; b[3] = 8'h78;
    do_reset();
    for (int c = 0; c < 6; c++) begin
      if (c < 4) drive(1'b1, b[c], 1'b0, 1'b1); else drive(1'b0, 8'h00, 1'b0, 1'b1);
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL single_in_ready c%0d: got %b want 1", c, in_ready); end
      n_cmp++; if (out_valid !== (c == 4)) begin n_err++; $display("FAIL single_out_valid c%0d: got %b want %b", c, out_valid, c == 4); end
      if (c == 4) begin
        n_cmp++; if (out_data !== 32'h12345678) begin n_err++; $display("FAIL single_out_data: got %h want 12345678", out_data); end
        n_cmp++; if (out_addr !== 16'h0) begin n_err++; $display("FAIL single_out_addr: got %h want 0000", out_addr); end
        $display("word addr=%h data=%h", out_addr, out_data);
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] b [8];
    logic [31:0] w1, w2;
    int k = 0;
    bit exp_ir;
    for (int i = 0; i < 8; i++) b[i] = 8'($urandom);
    w1 = {b[0], b[1], b[2], b[3]};
    w2 = {b[4], b[5], b[6], b[7]};
    do_reset();
    for (int c = 0; c < 16; c++) begin
      drive(k < 8, (k < 8) ? b[k] : 8'h00, 1'b0, c >= 12);
      exp_ir = !(c >= 7 && c <= 11);
      n_cmp++; if (in_ready !== exp_ir) begin n_err++; $display("FAIL bp_in_ready c%0d: got %b want %b", c, in_ready, exp_ir); end
      if (c >= 4 && c <= 12) begin
        n_cmp++; if (out_valid !== 1'b1 || out_data !== w1 || out_addr !== 16'h0) begin
          n_err++; $display("FAIL bp_hold c%0d: got v=%b %h@%h want v=1 %h@0000", c, out_valid, out_data, out_addr, w1);
        end
      end
      if (c == 13) begin
        n_cmp++; if (out_valid !== 1'b1 || out_data !== w2 || out_addr !== 16'h1) begin
          n_err++; $display("FAIL bp_second c%0d: got v=%b %h@%h want v=1 %h@0001", c, out_valid, out_data, out_addr, w2);
        end
      end
      if (c == 14) begin
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_drain: got %b want 0", out_valid); end
      end
      if (k < 8 && exp_ir) k++;
      tick();
    end
  endtask

  task automatic test_flush();
    logic [7:0] r [4];
    logic [31:0] wr;
    for (int i = 0; i < 4; i++) r[i] = 8'($urandom);
    wr = {r[0], r[1], r[2], r[3]};
    do_reset();
    for (int c = 0; c < 11; c++) begin
      case (c)
        0:          drive(1'b1, 8'hAA, 1'b0, 1'b1);
        1:          drive(1'b1, 8'hBB, 1'b0, 1'b1);
        2, 9:       drive(1'b0, 8'h00, 1'b1, 1'b1);
        4, 5, 6, 7: drive(1'b1, r[c-4], 1'b0, 1'b1);
        default:    drive(1'b0, 8'h00, 1'b0, 1'b1);
      endcase
      if (c == 2 || c == 3) begin
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL flush_in_ready c%0d: got %b want 1", c, in_ready); end
      end
      if (c == 3) begin
        n_cmp++; if (out_valid !== PAD) begin n_err++; $display("FAIL flush_partial_valid: got %b want %b", out_valid, PAD); end
        if (PAD) begin
          n_cmp++; if (out_data !== 32'hAABB0000 || out_addr !== 16'h0) begin
            n_err++; $display("FAIL flush_partial_word: got %h@%h want aabb0000@0000", out_data, out_addr);
          end
        end
      end
      if (c == 8) begin
        n_cmp++; if (out_valid !== 1'b1 || out_data !== wr || out_addr !== (PAD ? 16'h1 : 16'h0)) begin
          n_err++; $display("FAIL flush_next_word: got v=%b %h@%h want v=1 %h@%h", out_valid, out_data, out_addr, wr, PAD ? 16'h1 : 16'h0);
        end
      end
      if (c == 10) begin
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_empty: got %b want 0", out_valid); end
      end
      tick();
    end
  endtask

  task automatic test_pend();
    logic [7:0] b [6];
    logic [31:0] w1;
    for (int i = 0; i < 6; i++) b[i] = 8'($urandom);
    w1 = {b[0], b[1], b[2], b[3]};
    do_reset();
    for (int c = 0; c < 12; c++) begin
      if (c < 6) drive(1'b1, b[c], 1'b0, 1'b0);
      else if (c == 6) drive(1'b0, 8'h00, 1'b1, 1'b0);
      else drive(1'b0, 8'h00, 1'b0, c >= 10);
      if (c >= 7 && c <= 10) begin
        n_cmp++; if (in_ready !== !PAD) begin n_err++; $display("FAIL pend_in_ready c%0d: got %b want %b", c, in_ready, !PAD); end
      end
      if (c >= 4 && c <= 10) begin
        n_cmp++; if (out_valid !== 1'b1 || out_data !== w1 || out_addr !== 16'h0) begin
          n_err++; $display("FAIL pend_hold c%0d: got v=%b %h@%h want v=1 %h@0000", c, out_valid, out_data, out_addr, w1);
        end
      end
      if (c == 11) begin
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL pend_release: got %b want 1", in_ready); end
        n_cmp++; if (out_valid !== PAD) begin n_err++; $display("FAIL pend_word_valid: got %b want %b", out_valid, PAD); end
        if (PAD) begin
          n_cmp++; if (out_data !== {b[4], b[5], 16'h0} || out_addr !== 16'h1) begin
            n_err++; $display("FAIL pend_word: got %h@%h want %h@0001", out_data, out_addr, {b[4], b[5], 16'h0});
          end
        end
      end
      tick();
    end
  endtask

  task automatic test_wrap();
    logic [7:0] w [20];
    bit exp_v;
    for (int i = 0; i < 20; i++) w[i] = 8'($urandom);
    do_reset();
    for (int c = 0; c < 23; c++) begin
      drive(c < 20, (c < 20) ? w[c] : 8'h00, 1'b0, 1'b1);
      exp_v = (c >= 4) && (c % 4 == 0) && (c <= 20);
      n_cmp++; if (out_valid2 !== exp_v) begin n_err++; $display("FAIL wrap_valid c%0d: got %b want %b", c, out_valid2, exp_v); end
      if (exp_v) begin
        n_cmp++; if (out_addr2 !== 2'(c / 4 - 1) || out_data2 !== {w[c-4], w[c-3], w[c-2], w[c-1]}) begin
          n_err++; $display("FAIL wrap_word c%0d: got %h@%h want %h@%h", c, out_data2, out_addr2, {w[c-4], w[c-3], w[c-2], w[c-1]}, 2'(c / 4 - 1));
        end
        n_cmp++; if (out_addr !== 16'(c / 4 - 1)) begin n_err++; $display("FAIL wrap_addr16 c%0d: got %h want %h", c, out_addr, 16'(c / 4 - 1)); end
        $display("word addr2=%h data=%h", out_addr2, out_data2);
      end
      n_cmp++; if (wrapped2 !== (c >= 17)) begin n_err++; $display("FAIL wrap_flag c%0d: got %b want %b", c, wrapped2, c >= 17); end
      n_cmp++; if (wrapped !== 1'b0) begin n_err++; $display("FAIL wrap_flag16 c%0d: got %b want 0", c, wrapped); end
      tick();
    end
  endtask

  // Runs straight after test_wrap so the sticky flag is set going in.
  task automatic test_async_reset();
    logic [7:0] a [6];
    logic [7:0] n [4];
    for (int i = 0; i < 6; i++) a[i] = 8'($urandom);
    for (int i = 0; i < 4; i++) n[i] = 8'($urandom);
    for (int c = 0; c < 6; c++) begin
      drive(1'b1, a[c], 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL areset_pre_valid: got %b want 1", out_valid); end
    #2 r_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || out_data !== 32'h0 || out_addr !== 16'h0) begin
      n_err++; $display("FAIL areset_outputs: got v=%b %h@%h want v=0 00000000@0000", out_valid, out_data, out_addr);
    end
    n_cmp++; if (wrapped2 !== 1'b0 || out_addr2 !== 2'h0) begin
      n_err++; $display("FAIL areset_index2: got wrapped=%b addr=%h want 0 0", wrapped2, out_addr2);
    end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL areset_in_ready: got %b want 1", in_ready); end
    @(negedge clk);
    r_n = 1'b1;
    tick();
    for (int c = 0; c < 5; c++) begin
      if (c < 4) drive(1'b1, n[c], 1'b0, 1'b1); else drive(1'b0, 8'h00, 1'b0, 1'b1);
      if (c == 4) begin
        n_cmp++; if (out_valid !== 1'b1 || out_data !== {n[0], n[1], n[2], n[3]} || out_addr !== 16'h0) begin
          n_err++; $display("FAIL areset_next_word: got v=%b %h@%h want v=1 %h@0000", out_valid, out_data, out_addr, {n[0], n[1], n[2], n[3]});
        end
      end
      tick();
    end
  endtask

  task automatic test_random();
    bit exp_ir;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      drive($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 6);
      exp_ir = model_in_ready();
      n_cmp++; if (in_ready !== exp_ir) begin n_err++; $display("FAIL rand_in_ready c%0d: got %b want %b", c, in_ready, exp_ir); end
      n_cmp++; if (in_ready2 !== exp_ir) begin n_err++; $display("FAIL rand_in_ready2 c%0d: got %b want %b", c, in_ready2, exp_ir); end
      n_cmp++; if (out_valid !== m_ov) begin n_err++; $display("FAIL rand_out_valid c%0d: got %b want %b", c, out_valid, m_ov); end
      if (m_ov) begin
        n_cmp++; if (out_data !== m_word) begin n_err++; $display("FAIL rand_out_data c%0d: got %h want %h", c, out_data, m_word); end
        n_cmp++; if (out_addr !== 16'(m_hs)) begin n_err++; $display("FAIL rand_out_addr c%0d: got %h want %h", c, out_addr, 16'(m_hs)); end
        n_cmp++; if (out_addr2 !== 2'(m_hs)) begin n_err++; $display("FAIL rand_out_addr2 c%0d: got %h want %h", c, out_addr2, 2'(m_hs)); end
        if (out_ready) $display("word %0d addr=%h data=%h", m_hs, 16'(m_hs), m_word);
      end
      n_cmp++; if (wrapped2 !== (m_hs >= 4)) begin n_err++; $display("FAIL rand_wrapped2 c%0d: got %b want %b", c, wrapped2, m_hs >= 4); end
      model_advance();
      tick();
    end
  endtask

  initial begin
    r_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    r_n = 1'b1;
    tick();
    test_reset();
    test_single_word();
    test_backpressure();
    test_flush();
    test_pend();
    test_wrap();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
